// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Memory-side execution unit. Accepts one load/store micro-op at a time
//   from the reservation station, performs it byte-serially (little-endian,
//   unaligned, address wraps mod 2^32) on a byte-wide RAM port, and then
//   broadcasts the result with its destination tag for one cycle.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   op_in             issued opcode (LB..SW accepted in IDLE, others ignored)
//   value1_in         base address operand
//   value2_in         store data operand
//   imm_in            address offset
//   des_in            destination tag
//   busy              high while an access is in flight
//   result_data       load result (zero for stores), holds its last value
//   result_des        tag of the completed op for one cycle, NONE_TAG otherwise
//   ram_a             byte address
//   ram_dout          write byte
//   ram_wr            1 = write, 0 = read
//   ram_din           read byte, valid the cycle after its address
//   io_buffer_full    (only with LSU_IO_STALL_EN) stalls writes to the I/O
//                     window ram_a[17:16] == 2'b11
//
// Build option
//   LSU_IO_STALL_EN   when defined, adds io_buffer_full and the write stall.
// ---------------------------------------------------------------------------
module load_store_unit #(
   parameter logic [2:0] NONE_TAG = 3'd0,
   parameter logic [4:0] IDLE_OP  = 5'b11111
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  op_in,
   input  logic [31:0] value1_in,
   input  logic [31:0] value2_in,
   input  logic [31:0] imm_in,
   input  logic [2:0]  des_in,
   output logic        busy,
   output logic [31:0] result_data,
   output logic [2:0]  result_des,
   output logic [31:0] ram_a,
   output logic [7:0]  ram_dout,
   output logic        ram_wr,
`ifdef LSU_IO_STALL_EN
   input  logic        io_buffer_full,
`endif
   input  logic [7:0]  ram_din
);

   localparam logic [4:0] OP_LB  = 5'b10010;
   localparam logic [4:0] OP_LH  = 5'b10011;
   localparam logic [4:0] OP_LBU = 5'b10101;
   localparam logic [4:0] OP_LHU = 5'b10110;
   localparam logic [4:0] OP_SB  = 5'b10111;
   localparam logic [4:0] OP_SH  = 5'b11000;
   localparam logic [4:0] OP_SW  = 5'b11001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [4:0]  op_q, op_d;
   logic [2:0]  des_q, des_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        busy_q, busy_d;
   logic [31:0] result_data_q, result_data_d;
   logic [2:0]  result_des_q, result_des_d;
   logic [31:0] ram_a_q, ram_a_d;
   logic [7:0]  ram_dout_q, ram_dout_d;
   logic        ram_wr_q, ram_wr_d;
   logic [2:0]  n_bytes_s;
   logic [2:0]  n_bytes_next_s;
   logic [31:0] merged_s;
   logic        stall_s;

   function automatic logic is_mem_op(input logic [4:0] op);
      return (op != IDLE_OP) && (op >= OP_LB) && (op <= OP_SW);
   endfunction

   function automatic logic is_store(input logic [4:0] op);
      return (op >= OP_SB) && (op <= OP_SW);
   endfunction

   function automatic logic [2:0] num_bytes(input logic [4:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 3'd1;
         OP_LH, OP_LHU, OP_SH: return 3'd2;
         default:              return 3'd4;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [4:0] op, input logic [31:0] d);
      case (op)
         OP_LB:   return {{24{d[7]}}, d[7:0]};
         OP_LH:   return {{16{d[15]}}, d[15:0]};
         OP_LBU:  return {24'h000000, d[7:0]};
         OP_LHU:  return {16'h0000, d[15:0]};
         default: return d;
      endcase
   endfunction

   function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [2:0] idx);
      case (idx)
         3'd0:    return w[7:0];
         3'd1:    return w[15:8];
         3'd2:    return w[23:16];
         3'd3:    return w[31:24];
         default: return 8'h00;
      endcase
   endfunction

   // Write stall: an I/O-window write waits while the I/O buffer is full.
`ifdef LSU_IO_STALL_EN
   assign stall_s = (state_q == ST_WR) && io_buffer_full && (ram_a_q[17:16] == 2'b11);
`else
   assign stall_s = 1'b0;
`endif

   // Sequencing: acceptance, byte counting, load assembly and completion.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      addr_d        = addr_q;
      op_d          = op_q;
      des_d         = des_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      result_data_d = result_data_q;
      result_des_d  = NONE_TAG;
      n_bytes_s     = num_bytes(op_q);
      // ram_din in counter cycle c belongs to byte c-1
      merged_s      = rdata_q;
      case (cnt_q)
         3'd1:    merged_s[7:0]   = ram_din;
         3'd2:    merged_s[15:8]  = ram_din;
         3'd3:    merged_s[23:16] = ram_din;
         3'd4:    merged_s[31:24] = ram_din;
         default: merged_s        = rdata_q;
      endcase
      case (state_q)
         ST_IDLE: begin
            if (is_mem_op(op_in)) begin
               addr_d  = value1_in + imm_in;
               op_d    = op_in;
               des_d   = des_in;
               wdata_d = value2_in;
               rdata_d = 32'h0000_0000;
               cnt_d   = 3'd0;
               state_d = is_store(op_in) ? ST_WR : ST_RD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD: begin
            if (cnt_q == n_bytes_s) begin
               state_d       = ST_IDLE;
               result_data_d = extend(op_q, merged_s);
               result_des_d  = des_q;
            end else begin
               cnt_d   = cnt_q + 3'd1;
               rdata_d = merged_s;
            end
         end
         ST_WR: begin
            if (stall_s) begin
               cnt_d = cnt_q;
            end else if (cnt_q == (n_bytes_s - 3'd1)) begin
               state_d       = ST_IDLE;
               result_data_d = 32'h0000_0000;
               result_des_d  = des_q;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // RAM port and busy are precomputed from the next state so they are registered.
   always_comb begin
      n_bytes_next_s = num_bytes(op_d);
      busy_d         = (state_d != ST_IDLE);
      ram_a_d        = 32'h0000_0000;
      ram_dout_d     = 8'h00;
      ram_wr_d       = 1'b0;
      if ((state_d == ST_RD) && (cnt_d < n_bytes_next_s)) begin
         ram_a_d = addr_d + {29'd0, cnt_d};
      end else if (state_d == ST_WR) begin
         ram_a_d    = addr_d + {29'd0, cnt_d};
         ram_dout_d = pick_byte(wdata_d, cnt_d);
         ram_wr_d   = 1'b1;
      end else begin
         ram_a_d = 32'h0000_0000;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 3'd0;
         addr_q        <= 32'h0000_0000;
         op_q          <= IDLE_OP;
         des_q         <= NONE_TAG;
         wdata_q       <= 32'h0000_0000;
         rdata_q       <= 32'h0000_0000;
         busy_q        <= 1'b0;
         result_data_q <= 32'h0000_0000;
         result_des_q  <= NONE_TAG;
         ram_a_q       <= 32'h0000_0000;
         ram_dout_q    <= 8'h00;
         ram_wr_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         addr_q        <= addr_d;
         op_q          <= op_d;
         des_q         <= des_d;
         wdata_q       <= wdata_d;
         rdata_q       <= rdata_d;
         busy_q        <= busy_d;
         result_data_q <= result_data_d;
         result_des_q  <= result_des_d;
         ram_a_q       <= ram_a_d;
         ram_dout_q    <= ram_dout_d;
         ram_wr_q      <= ram_wr_d;
      end
   end

   assign busy        = busy_q;
   assign result_data = result_data_q;
   assign result_des  = result_des_q;
   assign ram_a       = ram_a_q;
   assign ram_dout    = ram_dout_q;
   // a stalled write must drop its strobe in the very cycle the stall appears
   assign ram_wr      = ram_wr_q & ~stall_s;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit. A transaction-level model turns every
//   accepted op into a list of expected per-cycle port values; a compare
//   process checks the DUT against that list on every falling edge. Directed
//   literal checks pin the model on the key scenarios.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

   localparam logic [4:0] OP_LB   = 5'b10010;
   localparam logic [4:0] OP_LH   = 5'b10011;
   localparam logic [4:0] OP_LW   = 5'b10100;
   localparam logic [4:0] OP_LBU  = 5'b10101;
   localparam logic [4:0] OP_LHU  = 5'b10110;
   localparam logic [4:0] OP_SB   = 5'b10111;
   localparam logic [4:0] OP_SH   = 5'b11000;
   localparam logic [4:0] OP_SW   = 5'b11001;
   localparam logic [4:0] OP_IDLE = 5'b11111;
   localparam logic [4:0] OP_ADD  = 5'b00000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  op_in = OP_IDLE;
   logic [31:0] value1_in = 32'd0;
   logic [31:0] value2_in = 32'd0;
   logic [31:0] imm_in = 32'd0;
   logic [2:0]  des_in = 3'd0;
   logic        busy;
   logic [31:0] result_data;
   logic [2:0]  result_des;
   logic [31:0] ram_a;
   logic [7:0]  ram_dout;
   logic        ram_wr;
   logic [7:0]  ram_din = 8'h00;
`ifdef LSU_IO_STALL_EN
   logic        io_buffer_full = 1'b0;
`endif

   int tests = 0;
   int fails = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .rst(rst), .op_in(op_in), .value1_in(value1_in),
      .value2_in(value2_in), .imm_in(imm_in), .des_in(des_in), .busy(busy),
      .result_data(result_data), .result_des(result_des), .ram_a(ram_a),
      .ram_dout(ram_dout), .ram_wr(ram_wr),
`ifdef LSU_IO_STALL_EN
      .io_buffer_full(io_buffer_full),
`endif
      .ram_din(ram_din)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- RAM contents: a few directed bytes, else a pattern
   logic [7:0] mem_ovr [logic [31:0]];

   function automatic logic [7:0] mem_rd(input logic [31:0] a);
      if (mem_ovr.exists(a)) return mem_ovr[a];
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction

   // RAM read port: the byte addressed in one cycle appears in the next
   logic [31:0] rd_a;
   always begin
      @(posedge clk);
      rd_a = ram_a;
      #1 ram_din = mem_rd(rd_a);
   end

   // ---------------- transaction-level model
   typedef struct {
      logic        busy;
      logic        wr;
      logic [31:0] a;
      logic        chk_a;
      logic [7:0]  dout;
      logic        chk_d;
      logic [2:0]  des;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] last_data = 32'd0;

   function automatic exp_t mk(input logic b, input logic w, input logic [31:0] a,
                               input logic ca, input logic [7:0] d, input logic cd,
                               input logic [2:0] des, input logic [31:0] data);
      exp_t e;
      e.busy = b; e.wr = w; e.a = a; e.chk_a = ca; e.dout = d; e.chk_d = cd;
      e.des = des; e.data = data;
      return e;
   endfunction

   function automatic int n_of(input logic [4:0] op);
      if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
      if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
      return 4;
   endfunction

   function automatic logic is_mem(input logic [4:0] op);
      return (op >= OP_LB) && (op <= OP_SW);
   endfunction

   task automatic model_accept(input logic [4:0] op, input logic [31:0] v1,
                               input logic [31:0] v2, input logic [31:0] imm,
                               input logic [2:0] des);
      logic [31:0] addr;
      logic [31:0] val;
      int n;
      addr = v1 + imm;
      n = n_of(op);
      if (op >= OP_SB) begin
         for (int k = 0; k < n; k++)
            exp_q.push_back(mk(1'b1, 1'b1, addr + 32'(k), 1'b1,
                               8'((v2 >> (8 * k)) & 32'hFF), 1'b1, 3'd0, last_data));
         exp_q.push_back(mk(1'b0, 1'b0, 32'd0, 1'b1, 8'h00, 1'b1, des, 32'd0));
         last_data = 32'd0;
      end else begin
         val = 32'd0;
         for (int k = 0; k < n; k++) begin
            exp_q.push_back(mk(1'b1, 1'b0, addr + 32'(k), 1'b1, 8'h00, 1'b0, 3'd0, last_data));
            val = val + ({24'd0, mem_rd(addr + 32'(k))} << (8 * k));
         end
         exp_q.push_back(mk(1'b1, 1'b0, 32'd0, 1'b0, 8'h00, 1'b0, 3'd0, last_data));
         if (op == OP_LB && val >= 32'd128)   val = val - 32'd256;
         if (op == OP_LH && val >= 32'd32768) val = val - 32'd65536;
         exp_q.push_back(mk(1'b0, 1'b0, 32'd0, 1'b1, 8'h00, 1'b1, des, val));
         last_data = val;
      end
   endtask

   // model step at each rising edge: retire the finished cycle, maybe accept
   always @(posedge clk) begin
      logic was_busy;
      if (!rst) begin
         exp_q.delete();
         last_data = 32'd0;
      end else begin
         was_busy = 1'b0;
         if (exp_q.size() > 0) begin
            was_busy = exp_q[0].busy;
            void'(exp_q.pop_front());
         end
         if (!was_busy && is_mem(op_in))
            model_accept(op_in, value1_in, value2_in, imm_in, des_in);
      end
   end

   // cycle compare against the model, away from the active edge
   always @(negedge clk) begin
      exp_t e;
      if (chk_en) begin
         if (exp_q.size() > 0) e = exp_q[0];
         else e = mk(1'b0, 1'b0, 32'd0, 1'b1, 8'h00, 1'b1, 3'd0, last_data);
         chk("cyc_busy", 32'(busy), 32'(e.busy));
         chk("cyc_ram_wr", 32'(ram_wr), 32'(e.wr));
         chk("cyc_result_des", 32'(result_des), 32'(e.des));
         chk("cyc_result_data", result_data, e.data);
         if (e.chk_a) chk("cyc_ram_a", ram_a, e.a);
         if (e.chk_d) chk("cyc_ram_dout", 32'(ram_dout), 32'(e.dout));
      end
   end

   // issue at a falling edge; the op is sampled at the next rising edge
   task automatic issue(input logic [4:0] op, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] imm, input logic [2:0] des);
      op_in = op; value1_in = v1; value2_in = v2; imm_in = imm; des_in = des;
      @(negedge clk);
      op_in = OP_IDLE;
   endtask

   logic [7:0]  sw_bytes [4];
   logic [31:0] wrap_a   [4];

   initial begin
      sw_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      wrap_a   = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
      mem_ovr[32'h0000_0103] = 8'h80;
      mem_ovr[32'h0000_0200] = 8'h34;
      mem_ovr[32'h0000_0201] = 8'h92;

      // reset state
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_result_des", 32'(result_des), 32'd0);
      chk("rst_result_data", result_data, 32'd0);
      chk("rst_ram_wr", 32'(ram_wr), 32'd0);
      chk("rst_ram_a", ram_a, 32'd0);
      chk("rst_ram_dout", 32'(ram_dout), 32'd0);
      rst = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);

      // 1: LB with sign extension, busy for exactly two cycles
      issue(OP_LB, 32'h100, 32'd0, 32'd3, 3'd5);
      chk("lb_c0_busy", 32'(busy), 32'd1);
      chk("lb_c0_ram_a", ram_a, 32'h103);
      @(negedge clk);
      chk("lb_c1_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("lb_done_busy", 32'(busy), 32'd0);
      chk("lb_result_des", 32'(result_des), 32'd5);
      chk("lb_result_data", result_data, 32'hFFFF_FF80);
      @(negedge clk);
      chk("lb_des_cleared", 32'(result_des), 32'd0);
      chk("lb_data_holds", result_data, 32'hFFFF_FF80);

      // 2: LHU then LH on the same two bytes
      issue(OP_LHU, 32'h200, 32'd0, 32'd0, 3'd1);
      repeat (3) @(negedge clk);
      chk("lhu_result_des", 32'(result_des), 32'd1);
      chk("lhu_result_data", result_data, 32'h0000_9234);
      issue(OP_LH, 32'h1F0, 32'd0, 32'h10, 3'd3);
      repeat (3) @(negedge clk);
      chk("lh_result_des", 32'(result_des), 32'd3);
      chk("lh_result_data", result_data, 32'hFFFF_9234);

      // 3: SW little-endian byte stream
      issue(OP_SW, 32'h10, 32'hDEAD_BEEF, 32'd0, 3'd2);
      for (int k = 0; k < 4; k++) begin
         chk("sw_ram_wr", 32'(ram_wr), 32'd1);
         chk("sw_ram_a", ram_a, 32'h10 + 32'(k));
         chk("sw_ram_dout", 32'(ram_dout), 32'(sw_bytes[k]));
         @(negedge clk);
      end
      chk("sw_result_des", 32'(result_des), 32'd2);
      chk("sw_result_data", result_data, 32'd0);
      chk("sw_done_busy", 32'(busy), 32'd0);
      @(negedge clk);

      // 4: ignored opcodes, and an op dropped while busy
      issue(OP_ADD, 32'h300, 32'd0, 32'd0, 3'd4);
      chk("add_busy", 32'(busy), 32'd0);
      chk("add_ram_wr", 32'(ram_wr), 32'd0);
      issue(OP_IDLE, 32'h300, 32'd0, 32'd0, 3'd4);
      chk("idle_busy", 32'(busy), 32'd0);
      issue(OP_LW, 32'h40, 32'd0, 32'd0, 3'd6);
      @(negedge clk);
      op_in = OP_LW; value1_in = 32'h80; des_in = 3'd7;
      @(negedge clk);
      op_in = OP_IDLE;
      repeat (3) @(negedge clk);
      chk("drop_result_des", 32'(result_des), 32'd6);
      chk("drop_result_data", result_data, 32'hE6E7_E4E5);
      @(negedge clk);
      chk("drop_no_second", 32'(busy), 32'd0);

      // 5a: reset two cycles into an LW aborts it silently
      issue(OP_LW, 32'h500, 32'd0, 32'd0, 3'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_result_des", 32'(result_des), 32'd0);
      chk("abort_ram_wr", 32'(ram_wr), 32'd0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("abort_no_bcast", 32'(result_des), 32'd0);
      end

      // 5b: SB accepted in the LB completion cycle
      issue(OP_LB, 32'h103, 32'd0, 32'd0, 3'd4);
      @(negedge clk);
      chk("b2b_lb_des", 32'(result_des), 32'd0);
      @(negedge clk);
      chk("b2b_lb_des", 32'(result_des), 32'd4);
      issue(OP_SB, 32'h60, 32'h0000_00A7, 32'd0, 3'd5);
      chk("b2b_sb_busy", 32'(busy), 32'd1);
      chk("b2b_sb_wr", 32'(ram_wr), 32'd1);
      chk("b2b_sb_a", ram_a, 32'h60);
      chk("b2b_sb_dout", 32'(ram_dout), 32'hA7);
      @(negedge clk);
      chk("b2b_sb_des", 32'(result_des), 32'd5);

      // 6: LW wrapping past 0xFFFFFFFF
      issue(OP_LW, 32'hFFFF_FFFE, 32'd0, 32'd0, 3'd3);
      for (int k = 0; k < 4; k++) begin
         chk("wrap_ram_a", ram_a, wrap_a[k]);
         @(negedge clk);
      end
      @(negedge clk);
      chk("wrap_result_des", 32'(result_des), 32'd3);
      chk("wrap_result_data", result_data, 32'hA4A5_A5A4);
      @(negedge clk);

`ifdef LSU_IO_STALL_EN
      // I/O-window SB held off for three cycles by a full I/O buffer
      chk_en = 1'b0;
      io_buffer_full = 1'b1;
      issue(OP_SB, 32'h0003_0000, 32'h0000_005A, 32'd0, 3'd2);
      for (int k = 0; k < 3; k++) begin
         chk("stall_wr_low", 32'(ram_wr), 32'd0);
         chk("stall_busy", 32'(busy), 32'd1);
         chk("stall_ram_a", ram_a, 32'h0003_0000);
         if (k < 2) @(negedge clk);
      end
      @(posedge clk);
      #1 io_buffer_full = 1'b0;
      @(negedge clk);
      chk("stall_resume_wr", 32'(ram_wr), 32'd1);
      chk("stall_resume_dout", 32'(ram_dout), 32'h5A);
      @(negedge clk);
      chk("stall_result_des", 32'(result_des), 32'd2);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk_en = 1'b1;
`endif

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-side execution unit. It is the responder to the reservation station's memory issue port. It accepts one load/store micro-op at a time (opcode, base, store data, immediate, destination tag) and performs the access byte-serially on the byte-wide RAM port. It then broadcasts the result with its tag on the memory result bus. While an access is in flight it holds busy high so the issuer withholds further memory ops.

Parameters:
NONE_TAG, 3'd0, tag value meaning "no broadcast / no destination"
IDLE_OP, 5'b11111, opcode meaning "no op issued this cycle"

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous reset, active-low (rst==0 resets on posedge clk)
op_in  input  5  issued opcode; LB=10010 LH=10011 LW=10100 LBU=10101 LHU=10110 SB=10111 SH=11000 SW=11001; IDLE_OP=none
value1_in  input  32  base address operand
value2_in  input  32  store data operand
imm_in  input  32  address offset
des_in  input  3  destination tag of the op
busy  output  1  high while an access is in flight
result_data  output  32  load result (zero for stores)
result_des  output  3  tag of completed op; NONE_TAG otherwise
ram_a  output  32  byte address
ram_dout  output  8  write byte
ram_wr  output  1  1 = write, 0 = read
ram_din  input  8  read byte; valid the cycle after its address is driven

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, byte counter=0, busy=0, result_des=NONE_TAG, result_data=0, ram_wr=0, ram_a=0, ram_dout=0. A reset mid-access aborts the access and broadcasts nothing.
- States: IDLE, RD, WR.
- Acceptance: in IDLE, op_in in LB..SW is accepted at the posedge.
  - Latch addr = value1_in + imm_in, truncated to 32 bits.
  - Latch op, des_in and value2_in.
  - Clear the counter. Next state is RD for loads, WR for stores.
- Ignored inputs: any other op_in (IDLE_OP, ALU/branch codes) is ignored. op_in presented while not IDLE is ignored and dropped; the issuer must gate on busy.
- Byte count: N = 1 for B/BU, 2 for H/HU, 4 for W. Byte order is little-endian. Alignment is not required. Byte k is at (addr+k) mod 2^32, so addresses wrap past 0xFFFFFFFF.
- RD state (N+1 cycles, counter c = 0..N):
  - Drive ram_a = addr+c while c<N, and ram_wr=0.
  - When c>=1, capture ram_din into byte c-1.
  - At c==N, go to IDLE, with result_data = assembled value and result_des = des.
- Extension: LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW is a full 32-bit word.
- WR state (N cycles, c = 0..N-1):
  - Drive ram_a = addr+c, ram_wr=1, ram_dout = value2[8c+7:8c].
  - At c==N-1, go to IDLE, with result_data=0 and result_des=des.
- Outputs outside RD/WR: ram_wr=0; ram_a and ram_dout are 0.
- Latency, with the op sampled at edge E0:
  - A load result is visible after edge E(N+1): LB after E2, LW after E5.
  - A store completion is visible after edge EN.
- Result bus: result_des/result_data hold for exactly one cycle, then result_des returns to NONE_TAG. result_data holds its last value.
- busy is registered and equals (state != IDLE). It rises the cycle after acceptance and falls in the same cycle the result is presented.
- A new op may be accepted in that presentation cycle (back-to-back).

Optional Feature:
LSU_IO_STALL_EN:
- Defined:
  - Adds input io_buffer_full (1 bit).
  - In WR, if io_buffer_full==1 and ram_a[17:16]==2'b11, ram_wr is forced to 0 and the counter holds. The write resumes when the condition clears.
  - Reads are unaffected.
- Undefined: the port is absent and writes never stall.

Test Plan:
1. LB: value1=0x100, imm=3, des=5, ram_din=0x80 for 0x103 -> ram_a=0x103 read; after E2, result_data=0xFFFFFF80, result_des=5 for one cycle; busy high for exactly 2 cycles.
2. LHU: addr 0x200, bytes 0x34, 0x92 -> result_data=0x00009234 after E3. The same bytes with LH -> 0xFFFF9234.
3. SW: value1=0x10, imm=0, value2=0xDEADBEEF, des=2 -> writes EF, BE, AD, DE to 0x10..0x13 with ram_wr=1 for 4 cycles; result_des=2, result_data=0 after E4.
4. Ignored ops: op=ADD(00000), then IDLE_OP -> no busy, no RAM activity. An LW issued while busy -> dropped; the first op completes normally.
5. Reset and back-to-back:
   - rst=0 two cycles into an LW -> busy=0, result_des=0, ram_wr=0, and no broadcast afterwards.
   - Back-to-back: an SB accepted in the LB completion cycle -> starts on the next cycle.
6. Wrap-around: LW with value1=0xFFFFFFFE, imm=0 -> addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001.
   - With LSU_IO_STALL_EN, an SB to 0x30000 with io_buffer_full=1 for 3 cycles -> the write is delayed 3 cycles.
